// File: rtl/scan_decoder.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : scan_decoder                                                 |
// | Description : Clocked active-low 1-of-N select driver. Auto mode scans the |
// |               selects 0..last_sel at CLK_DIV cycles per slot. Manual mode  |
// |               holds a loaded address. Every select change is preceded by   |
// |               BLANK_CYC all-ones cycles so the driven bank does not ghost. |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module scan_decoder #(
    parameter int SEL_W     = 3,
    parameter int CLK_DIV   = 1000,
    parameter int BLANK_CYC = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [2:0]            en,
    input  logic                  mode,
    input  logic [SEL_W-1:0]      addr_in,
    input  logic                  load,
    input  logic [SEL_W-1:0]      last_sel,
    output logic [(2**SEL_W)-1:0] out,
    output logic [SEL_W-1:0]      cur_sel,
    output logic                  slot_tick
);

    localparam int                 c_num_out  = 2**SEL_W;
    localparam int                 c_cnt_w    = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [c_cnt_w-1:0] c_cnt_last = c_cnt_w'(CLK_DIV - 1);
    localparam logic [c_cnt_w-1:0] c_blank    = c_cnt_w'(BLANK_CYC);
    localparam logic [2:0]         c_en_code  = 3'b100;

    logic [SEL_W-1:0]     r_sel;
    logic [c_cnt_w-1:0]   r_cnt;
    logic                 r_en_q;
    logic                 r_auto_q;
    logic                 r_tick;
    logic [c_num_out-1:0] r_out;

    logic                 w_enabled;
    logic [SEL_W-1:0]     w_sel_nxt;
    logic [SEL_W-1:0]     w_sel_adv;
    logic [SEL_W-1:0]     w_sel_inv;
    logic [c_cnt_w-1:0]   w_cnt_nxt;
    logic                 w_en_q_nxt;
    logic                 w_auto_nxt;
    logic                 w_tick_nxt;
    logic [c_num_out-1:0] w_dec;
    logic [c_num_out-1:0] w_out_nxt;

    assign w_enabled = (en == c_en_code);

    // Wrap to 0 once sel reaches or passes last_sel, so lowering last_sel mid-scan recovers
    assign w_sel_adv = (r_sel >= last_sel) ? '0 : r_sel + 1'b1;

    // Next-state selection, highest priority first: disable, enable edge, auto, manual
    always_comb begin
        w_sel_nxt  = r_sel;
        w_cnt_nxt  = r_cnt;
        w_en_q_nxt = 1'b1;
        w_auto_nxt = mode;
        w_tick_nxt = 1'b0;
        if (!w_enabled) begin
            w_sel_nxt  = '0;
            w_cnt_nxt  = '0;
            w_en_q_nxt = 1'b0;
            w_auto_nxt = 1'b0;
        end else if (!r_en_q) begin
            w_sel_nxt = '0;
            w_cnt_nxt = '0;
        end else if (mode) begin
            if (!r_auto_q) begin
                // first auto cycle after manual: restart the slot timer, keep sel
                w_cnt_nxt = '0;
            end else if (r_cnt == c_cnt_last) begin
                w_cnt_nxt  = '0;
                w_tick_nxt = 1'b1;
                w_sel_nxt  = w_sel_adv;
            end else begin
                w_cnt_nxt = r_cnt + 1'b1;
            end
        end else begin
            if (load) begin
                w_sel_nxt = addr_in;
                w_cnt_nxt = '0;
            end else if (r_cnt < c_blank) begin
                // saturate at the blank length; a larger count left by auto mode holds
                w_cnt_nxt = r_cnt + 1'b1;
            end
        end
    end

    // Output decode from the post-edge state: bit (NUM_OUT-1-sel) == bit ~sel goes low
    always_comb begin
        w_sel_inv        = ~w_sel_nxt;
        w_dec            = '1;
        w_dec[w_sel_inv] = 1'b0;
        w_out_nxt        = w_dec;
        if (!w_enabled || (w_cnt_nxt < c_blank)) begin
            w_out_nxt = '1;
        end
    end

    // State and registered outputs, asynchronously forced to the idle state by rst
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_sel    <= '0;
            r_cnt    <= '0;
            r_en_q   <= 1'b0;
            r_auto_q <= 1'b0;
            r_tick   <= 1'b0;
            r_out    <= '1;
        end else begin
            r_sel    <= w_sel_nxt;
            r_cnt    <= w_cnt_nxt;
            r_en_q   <= w_en_q_nxt;
            r_auto_q <= w_auto_nxt;
            r_tick   <= w_tick_nxt;
            r_out    <= w_out_nxt;
        end
    end

    assign out       = r_out;
    assign cur_sel   = r_sel;
    assign slot_tick = r_tick;

endmodule
`default_nettype wire

// File: tb/tb_scan_decoder.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : tb_scan_decoder                                              |
// | Description : Self-checking bench for scan_decoder (SEL_W=3, CLK_DIV=8,    |
// |               BLANK_CYC=2): vector table, directed sequences, and random   |
// |               stimulus against a behavioural model.                        |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module tb_scan_decoder;

    localparam int SEL_W     = 3;
    localparam int CLK_DIV   = 8;
    localparam int BLANK_CYC = 2;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [2:0] en = 3'b000;
    logic       mode = 1'b0;
    logic [2:0] addr_in = 3'd0;
    logic       load = 1'b0;
    logic [2:0] last_sel = 3'd7;
    logic [7:0] dout;
    logic [2:0] dsel;
    logic       dtick;

    int n_checks = 0;
    int n_errors = 0;

    scan_decoder #(
        .SEL_W    (SEL_W),
        .CLK_DIV  (CLK_DIV),
        .BLANK_CYC(BLANK_CYC)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .en       (en),
        .mode     (mode),
        .addr_in  (addr_in),
        .load     (load),
        .last_sel (last_sel),
        .out      (dout),
        .cur_sel  (dsel),
        .slot_tick(dtick)
    );

    always #5 clk = ~clk;

    // safety net so the run always ends
    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not complete, errors=%0d", n_errors);
        $fatal(1, "watchdog");
    end

    // ---------------- behavioural reference model ----------------
    int m_sel  = 0;
    int m_cnt  = 0;
    bit m_enq  = 0;
    bit m_auto = 0;
    bit m_tick = 0;
    int m_outv = 'hFF;

    function automatic int dec(input int s);
        return 'hFF ^ ('h80 >> s);
    endfunction

    task automatic m_reset();
        m_sel = 0; m_cnt = 0; m_enq = 0; m_auto = 0; m_tick = 0; m_outv = 'hFF;
    endtask

    task automatic m_step();
        bit on;
        on     = (en == 3'b100);
        m_tick = 0;
        if (rst || !on) begin
            m_sel = 0; m_cnt = 0; m_enq = 0; m_auto = 0;
        end else if (!m_enq) begin
            m_sel = 0; m_cnt = 0; m_enq = 1; m_auto = mode;
        end else if (mode) begin
            if (!m_auto) m_cnt = 0;
            else if (m_cnt == CLK_DIV - 1) begin
                m_cnt  = 0;
                m_tick = 1;
                m_sel  = (m_sel >= int'(last_sel)) ? 0 : m_sel + 1;
            end else m_cnt++;
            m_auto = 1;
        end else begin
            m_auto = 0;
            if (load) begin
                m_sel = int'(addr_in);
                m_cnt = 0;
            end else if (m_cnt < BLANK_CYC) m_cnt++;
        end
        m_outv = (rst || !on || m_cnt < BLANK_CYC) ? 'hFF : dec(m_sel);
    endtask

    // ---------------- checking helpers ----------------
    task automatic check(input string name, input int got, input int exp);
        n_checks++;
        if (got != exp) begin
            n_errors++;
            $display("FAIL %s at %0t: got=%0h expected=%0h", name, $time, got, exp);
        end
    endtask

    task automatic step(input bit vs_model);
        @(posedge clk);
        m_step();
        #1;
        if (vs_model) begin
            check("rand_out", int'(dout), m_outv);
            check("rand_sel", int'(dsel), m_sel);
            check("rand_tick", int'(dtick), int'(m_tick));
        end
    endtask

    typedef struct {
        logic [2:0] v_en;
        logic       v_mode;
        logic [2:0] v_addr;
        logic       v_load;
        logic [7:0] x_out;
        logic [2:0] x_sel;
        logic       x_tick;
    } vec_t;

    vec_t tbl[19];

    initial begin
        // enable edge, manual load, load during blank, enable gating, manual->auto
        tbl[0]  = '{3'b100, 1'b0, 3'd0, 1'b0, 8'hFF, 3'd0, 1'b0};
        tbl[1]  = '{3'b100, 1'b0, 3'd0, 1'b0, 8'hFF, 3'd0, 1'b0};
        tbl[2]  = '{3'b100, 1'b0, 3'd0, 1'b0, 8'h7F, 3'd0, 1'b0};
        tbl[3]  = '{3'b100, 1'b0, 3'd5, 1'b1, 8'hFF, 3'd5, 1'b0};
        tbl[4]  = '{3'b100, 1'b0, 3'd5, 1'b0, 8'hFF, 3'd5, 1'b0};
        tbl[5]  = '{3'b100, 1'b0, 3'd5, 1'b1, 8'hFF, 3'd5, 1'b0};
        tbl[6]  = '{3'b100, 1'b0, 3'd5, 1'b0, 8'hFF, 3'd5, 1'b0};
        tbl[7]  = '{3'b100, 1'b0, 3'd5, 1'b0, 8'hFB, 3'd5, 1'b0};
        tbl[8]  = '{3'b100, 1'b0, 3'd5, 1'b0, 8'hFB, 3'd5, 1'b0};
        tbl[9]  = '{3'b101, 1'b0, 3'd5, 1'b0, 8'hFF, 3'd0, 1'b0};
        tbl[10] = '{3'b100, 1'b0, 3'd5, 1'b0, 8'hFF, 3'd0, 1'b0};
        tbl[11] = '{3'b100, 1'b0, 3'd5, 1'b0, 8'hFF, 3'd0, 1'b0};
        tbl[12] = '{3'b100, 1'b0, 3'd5, 1'b0, 8'h7F, 3'd0, 1'b0};
        tbl[13] = '{3'b100, 1'b1, 3'd3, 1'b1, 8'hFF, 3'd0, 1'b0};
        tbl[14] = '{3'b100, 1'b1, 3'd3, 1'b1, 8'hFF, 3'd0, 1'b0};
        tbl[15] = '{3'b100, 1'b1, 3'd3, 1'b0, 8'h7F, 3'd0, 1'b0};
        tbl[16] = '{3'b111, 1'b1, 3'd3, 1'b0, 8'hFF, 3'd0, 1'b0};
        tbl[17] = '{3'b110, 1'b1, 3'd3, 1'b0, 8'hFF, 3'd0, 1'b0};
        tbl[18] = '{3'b000, 1'b1, 3'd3, 1'b0, 8'hFF, 3'd0, 1'b0};

        // reset values, then release with the block disabled
        repeat (2) @(posedge clk);
        #1;
        m_reset();
        check("reset_out", int'(dout), 'hFF);
        check("reset_sel", int'(dsel), 0);
        check("reset_tick", int'(dtick), 0);
        rst = 1'b0;
        en  = 3'b000;
        step(0);
        check("release_out", int'(dout), 'hFF);

        // vector table
        for (int i = 0; i < 19; i++) begin
            en = tbl[i].v_en; mode = tbl[i].v_mode;
            addr_in = tbl[i].v_addr; load = tbl[i].v_load;
            step(0);
            check("tbl_out", int'(dout), int'(tbl[i].x_out));
            check("tbl_sel", int'(dsel), int'(tbl[i].x_sel));
            check("tbl_tick", int'(dtick), int'(tbl[i].x_tick));
        end
        load = 1'b0;

        // full auto scan: 2 blank + 6 decoded cycles per slot
        en = 3'b000; step(0);
        en = 3'b100; mode = 1'b1; last_sel = 3'd7;
        for (int s = 0; s < 9; s++) begin
            for (int c = 0; c < CLK_DIV; c++) begin
                step(0);
                check("scan_out", int'(dout), (c < BLANK_CYC) ? 'hFF : dec(s % 8));
                check("scan_sel", int'(dsel), s % 8);
                check("scan_tick", int'(dtick), (c == 0 && s > 0) ? 1 : 0);
            end
        end

        // asynchronous reset mid-slot, right after an advance raised slot_tick
        step(0);
        #2;
        rst = 1'b1;
        #1;
        m_reset();
        check("arst_out", int'(dout), 'hFF);
        check("arst_sel", int'(dsel), 0);
        check("arst_tick", int'(dtick), 0);
        en = 3'b000;
        step(0);
        rst = 1'b0;
        step(0);
        check("arst_release_out", int'(dout), 'hFF);

        // short scan, then last_sel lowered below the current select
        en = 3'b100; mode = 1'b1; last_sel = 3'd2;
        step(0);
        repeat (8) step(0);
        check("short_sel1", int'(dsel), 1);
        repeat (8) step(0);
        check("short_sel2", int'(dsel), 2);
        repeat (8) step(0);
        check("short_wrap", int'(dsel), 0);
        repeat (16) step(0);
        check("short_sel2b", int'(dsel), 2);
        last_sel = 3'd1;
        repeat (7) step(0);
        check("lower_hold", int'(dsel), 2);
        step(0);
        check("lower_wrap_sel", int'(dsel), 0);
        check("lower_wrap_tick", int'(dtick), 1);

        // mode switch auto -> manual -> auto at sel 3
        en = 3'b000; step(0);
        en = 3'b100; mode = 1'b1; last_sel = 3'd7;
        step(0);
        repeat (28) step(0);
        check("sw_auto_out", int'(dout), 'hEF);
        check("sw_auto_sel", int'(dsel), 3);
        mode = 1'b0;
        step(0);
        check("sw_man_out", int'(dout), 'hEF);
        repeat (3) step(0);
        check("sw_man_hold", int'(dout), 'hEF);
        check("sw_man_tick", int'(dtick), 0);
        mode = 1'b1;
        step(0);
        check("sw_back_out", int'(dout), 'hFF);
        repeat (2) step(0);
        check("sw_back_dec", int'(dout), 'hEF);
        repeat (5) step(0);
        check("sw_back_sel7", int'(dsel), 3);
        check("sw_back_tick7", int'(dtick), 0);
        step(0);
        check("sw_back_sel8", int'(dsel), 4);
        check("sw_back_tick8", int'(dtick), 1);

        // randomized stimulus against the model
        for (int k = 0; k < 3000; k++) begin
            en = ($urandom_range(0, 99) < 4) ? 3'($urandom) : 3'b100;
            if ($urandom_range(0, 49) == 0) mode = ~mode;
            load    = ($urandom_range(0, 5) == 0);
            addr_in = 3'($urandom);
            if ($urandom_range(0, 99) == 0) last_sel = 3'($urandom);
            rst = ($urandom_range(0, 299) == 0);
            step(1);
        end
        rst = 1'b0;

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/scan_decoder.md
# scan_decoder

Parametrised, clocked successor to the team's 3-to-8 active-low decoder. It drives the active-low select lines of a multiplexed latch or display bank. In auto mode it scans the outputs itself at a programmable rate. In manual mode it holds a loaded address. In both modes it inserts a blanking gap on every select change to prevent ghosting. It keeps the same 3-bit enable code and MSB-first output ordering as the combinational part it replaces.

## Interface
- SEL_W, 3: select width; NUM_OUT = 2**SEL_W outputs.
- CLK_DIV, 1000: clock cycles per scan slot in auto mode; must be ≥ BLANK_CYC+2.
- BLANK_CYC, 4: all-ones cycles after every select change; 0 disables blanking.
- clk  in  1  single clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- en  in  3  block enabled only when en == 3'b100; any other value disables it.
- mode  in  1  0 = manual, 1 = auto-scan.
- addr_in  in  SEL_W  manual address.
- load  in  1  manual strobe; sampled only when enabled and mode = 0.
- last_sel  in  SEL_W  highest select visited by auto-scan; the scan wraps to 0 after it.
- out  out  NUM_OUT  active-low one-hot select, registered.
- cur_sel  out  SEL_W  current select register.
- slot_tick  out  1  one-cycle pulse on each auto advance.

## Operation
- State: sel (SEL_W bits), cnt (ceil(log2(CLK_DIV)) bits), en_q (enabled last cycle).
- Decode: sel = k drives out[NUM_OUT-1-k] low and all other bits high. For SEL_W = 3: sel 0 → 8'h7F, 1 → 8'hBF, 7 → 8'hFE.
- out is all ones when the block is disabled or when cnt < BLANK_CYC. Otherwise out = decode(sel).
- out is a registered function of the post-edge state, so it changes on the same edge as sel and cnt, with no extra cycle of latency.
- Disabled (en ≠ 3'b100), per edge:
  - sel ← 0, cnt ← 0, slot_tick ← 0, out ← all ones.
  - load and mode are ignored.
- Enable assertion, the first edge with en == 3'b100 while en_q = 0:
  - sel ← 0, cnt ← 0.
  - A blanking window starts.
- Auto mode (mode = 1), enabled:
  - cnt increments every cycle.
  - When cnt == CLK_DIV-1: cnt ← 0, slot_tick ← 1 for one cycle, and sel advances.
  - Advance rule: if sel ≥ last_sel, sel ← 0; otherwise sel ← sel+1. This also covers last_sel being lowered below the current sel mid-scan.
  - load is ignored.
- Manual mode (mode = 0), enabled:
  - load = 1: sel ← addr_in and cnt ← 0, starting a blanking window. This happens even if addr_in equals sel.
  - load = 0: cnt increments until it reaches BLANK_CYC, then saturates there.
  - slot_tick stays 0. last_sel is ignored; addr_in > last_sel is legal.
- Mode switch:
  - Auto → manual: sel holds; cnt continues under the manual (saturating) rule.
  - Manual → auto: cnt ← 0 on the first auto edge; sel continues from its held value.
  - Neither switch blanks out by itself, except through the cnt < BLANK_CYC rule.
- Simultaneous events:
  - Disable has priority over everything.
  - Enable assertion has priority over load and over the auto advance.

## Timing
- Reset (asynchronous, while rst high):
  - out = all ones, cur_sel = 0, slot_tick = 0.
  - cnt = 0, en_q = 0.
- Leaving reset: the first active edge is an ordinary enable check.
- Auto slot period: exactly CLK_DIV cycles.
  - The edge where sel changes also begins BLANK_CYC all-ones cycles.
  - The decoded value then holds for CLK_DIV-BLANK_CYC cycles.
- slot_tick is high in the cycle following the advance edge, coincident with the new cur_sel.
- Manual load sampled at edge E:
  - cur_sel = addr_in from E.
  - out = all ones for BLANK_CYC cycles.
  - Decoded value appears at edge E+BLANK_CYC.
- Disable seen at edge E: out = all ones from E.
- rst asserted mid-slot: all outputs are forced to reset values immediately, independent of clk.

## Test plan
All scenarios use SEL_W = 3, CLK_DIV = 8, BLANK_CYC = 2.
1. Reset: assert rst mid-operation with en = 3'b100 → out = 8'hFF, cur_sel = 0, slot_tick = 0 without waiting for a clock edge. Release rst with en = 3'b000 → out stays 8'hFF.
2. Auto full scan: mode = 1, last_sel = 7, en = 3'b100 → per 8-cycle slot, 2 cycles of FF then 6 cycles of the decoded value. Sequence 7F, BF, DF, EF, F7, FB, FD, FE, then 7F again. slot_tick pulses every 8 cycles.
3. Short scan and last_sel change: last_sel = 2 → cur_sel cycles 0, 1, 2, 0. Set last_sel = 1 while cur_sel = 2 → next advance goes to 0.
4. Manual load: mode = 0, load with addr_in = 5 → cur_sel = 5, out FF for 2 cycles then 8'hFB and held. No slot_tick. A load pulse during the blanking window restarts the 2-cycle blank.
5. Enable gating: cycle en through 3'b000, 3'b101, 3'b110, 3'b111 during a scan → out = 8'hFF and cur_sel = 0 each time. Re-enable → blank 2 cycles, then 7F.
6. Mode switch: switch auto → manual while cur_sel = 3 → out holds 8'hEF. Switch back to auto → the next advance to sel 4 comes 8 cycles after the switch edge.
